line_anim_sequencer: RTL

//  Parametrised animation controller feeding line_drawer: steps through N_SEG segments from an external table,

---
 rtl/line_pkg.sv | 23 ++
 rtl/line_anim_sequencer_dwell_timer.sv | 22 ++
 rtl/line_anim_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/line_pkg.sv
// line_pkg: shared types and constants for the line animation sequencer
package line_pkg;
   localparam int XW = 10;
   localparam int YW = 9;
   localparam logic COLOR_WHITE = 1'b1;
   localparam logic COLOR_BLACK = 1'b0;
   typedef struct packed {
      logic [XW-1:0] x0;
      logic [YW-1:0] y0;
      logic [XW-1:0] x1;
      logic [YW-1:0] y1;
   } seg_t;
   typedef enum logic [2:0] {
      CLEAR_ISSUE,
      CLEAR_WAIT,
      IDLE,
      DRAW_ISSUE,
      DRAW_WAIT,
      DWELL,
      ERASE_ISSUE,
      ERASE_WAIT
   } seq_state_t;
endpackage

// File: rtl/line_anim_sequencer_dwell_timer.sv
// dwell_timer: counts enabled cycles and flags the last one of the dwell period
module dwell_timer #(
   parameter int unsigned DWELL_CYCLES = 25_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int unsigned CW = $clog2(DWELL_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);
   logic [CW-1:0] count_q, count_d;
   assign tc = en && count_q == LAST;
   // count only enabled cycles; restart on clear or terminal count so it never overflows
   always_comb count_d = (clr || tc) ? '0 : en ? count_q + CW'(1) : count_q;
   // counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) count_q <= '0;
      else count_q <= count_d;
   end
endmodule

// File: rtl/line_anim_sequencer.sv
// line_anim_sequencer: steps a segment table through line_drawer with dwell, optional erase and screen clear
module line_anim_sequencer
   import line_pkg::*;
#(
   parameter int unsigned N_SEG        = 6,
   parameter int unsigned SCREEN_W     = 640,
   parameter int unsigned SCREEN_H     = 480,
   parameter int unsigned DWELL_CYCLES = 25_000_000,
   parameter bit          ERASE_PREV   = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     clear_req,
   output logic [$clog2(N_SEG)-1:0] seg_idx,
   input  logic [XW-1:0]            seg_x0,
   input  logic [YW-1:0]            seg_y0,
   input  logic [XW-1:0]            seg_x1,
   input  logic [YW-1:0]            seg_y1,
   output logic                     ld_start,
   output logic [XW-1:0]            ld_x0,
   output logic [YW-1:0]            ld_y0,
   output logic [XW-1:0]            ld_x1,
   output logic [YW-1:0]            ld_y1,
   output logic                     ld_color,
   input  logic                     ld_done,
   output logic                     busy,
   output logic                     clearing
);
   localparam int unsigned IW = $clog2(N_SEG);
   localparam int unsigned COLW = SCREEN_W > 1 ? $clog2(SCREEN_W) : 1;
   localparam logic [IW-1:0] SEG_LAST = IW'(N_SEG - 1);
   localparam logic [COLW-1:0] COL_LAST = COLW'(SCREEN_W - 1);
   seq_state_t state_q, state_d;
   logic [COLW-1:0] col_q, col_d;
   logic [IW-1:0] seg_idx_q, seg_idx_d;
   logic prev_valid_q, prev_valid_d;
   logic ld_color_q, ld_color_d;
   logic ld_start_q, ld_start_d;
   seg_t prev_q, prev_d, ld_q, ld_d, seg_in, clear_line;
   logic dwell_tc;
   assign seg_in = '{x0: seg_x0, y0: seg_y0, x1: seg_x1, y1: seg_y1};
   assign clear_line = '{x0: XW'(col_q), y0: '0, x1: XW'(col_q), y1: YW'(SCREEN_H - 1)};
   assign seg_idx = seg_idx_q;
   assign ld_start = ld_start_q;
   assign ld_x0 = ld_q.x0;
   assign ld_y0 = ld_q.y0;
   assign ld_x1 = ld_q.x1;
   assign ld_y1 = ld_q.y1;
   assign ld_color = ld_color_q;
   assign busy = state_q != IDLE && state_q != DWELL;
   assign clearing = state_q == CLEAR_ISSUE || state_q == CLEAR_WAIT;
   dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_dwell (
      .clk  (clk),
      .reset(reset),
      .clr  (clear_req || (state_q == DRAW_WAIT && ld_done)),
      .en   (state_q == DWELL && enable),
      .tc   (dwell_tc)
   );
   // sequencing: clear sweep, draw, dwell, erase; clear_req overrides everything including a pending done
   always_comb begin
      state_d = state_q;
      col_d = col_q;
      seg_idx_d = seg_idx_q;
      prev_valid_d = prev_valid_q;
      prev_d = prev_q;
      ld_d = ld_q;
      ld_color_d = ld_color_q;
      ld_start_d = 1'b0;
      if (clear_req) begin
         state_d = CLEAR_ISSUE;
         col_d = '0;
      end else begin
         case (state_q)
            CLEAR_ISSUE: begin
               ld_d = clear_line;
               ld_color_d = COLOR_BLACK;
               ld_start_d = 1'b1;
               state_d = CLEAR_WAIT;
            end
            CLEAR_WAIT: if (ld_done) begin
               col_d = col_q == COL_LAST ? '0 : col_q + COLW'(1);
               seg_idx_d = col_q == COL_LAST ? '0 : seg_idx_q;
               prev_valid_d = col_q == COL_LAST ? 1'b0 : prev_valid_q;
               state_d = col_q == COL_LAST ? IDLE : CLEAR_ISSUE;
            end
            IDLE: state_d = enable ? DRAW_ISSUE : IDLE;
            DRAW_ISSUE: begin
               ld_d = seg_in;
               prev_d = seg_in;
               ld_color_d = COLOR_WHITE;
               ld_start_d = 1'b1;
               state_d = DRAW_WAIT;
            end
            DRAW_WAIT: if (ld_done) begin
               prev_valid_d = 1'b1;
               state_d = DWELL;
            end
            DWELL: if (dwell_tc) begin
               seg_idx_d = seg_idx_q == SEG_LAST ? '0 : seg_idx_q + IW'(1);
               state_d = (ERASE_PREV && prev_valid_q) ? ERASE_ISSUE : DRAW_ISSUE;
            end
            ERASE_ISSUE: begin
               ld_d = prev_q;
               ld_color_d = COLOR_BLACK;
               ld_start_d = 1'b1;
               state_d = ERASE_WAIT;
            end
            ERASE_WAIT: state_d = ld_done ? DRAW_ISSUE : ERASE_WAIT;
            default: state_d = CLEAR_ISSUE;
         endcase
      end
   end
   // state and registered line_drawer outputs; reset starts a fresh screen clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CLEAR_ISSUE;
         col_q <= '0;
         seg_idx_q <= '0;
         prev_valid_q <= 1'b0;
         prev_q <= '0;
         ld_q <= '0;
         ld_color_q <= 1'b0;
         ld_start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q <= col_d;
         seg_idx_q <= seg_idx_d;
         prev_valid_q <= prev_valid_d;
         prev_q <= prev_d;
         ld_q <= ld_d;
         ld_color_q <= ld_color_d;
         ld_start_q <= ld_start_d;
      end
   end
endmodule
